refresh_scheduler: RTL and testbench



---
 rtl/refresh_pkg.sv | 20 ++
 rtl/refresh_bank_timer.sv | 48 ++++
 rtl/refresh_scheduler.sv | 130 +++++++++++++
 tb/tb_refresh_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/refresh_pkg.sv
// Shared types and width helpers for the multi-bank refresh scheduler.
package refresh_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      BUSY
   } sched_state_t;

   // Bank index width; a single bank still gets a 1-bit index.
   function automatic int bank_w(input int num_banks);
      return (num_banks > 1) ? $clog2(num_banks) : 1;
   endfunction

   // Credit counter width; must hold MAX_POSTPONE+1.
   function automatic int pend_w(input int max_postpone);
      return $clog2(max_postpone + 2);
   endfunction

endpackage

// File: rtl/refresh_bank_timer.sv
// Per-bank retention timer with a saturating refresh-credit counter.
// A credit is earned each time the timer wraps and consumed by 'dec'.
module refresh_bank_timer
   import refresh_pkg::*;
#(
   parameter int INTERVAL     = 5000,
   parameter int MAX_POSTPONE = 3,
   parameter int OFFSET       = 0,
   localparam int PEND_W      = pend_w(MAX_POSTPONE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dec,
   output logic [PEND_W-1:0] pending,
   output logic              urgent,
   output logic              overflow_err
);

   localparam int CNT_W    = $clog2(INTERVAL);
   localparam int PEND_MAX = MAX_POSTPONE + 1;

   logic [CNT_W-1:0] cnt;
   logic             wrap;

   assign wrap   = (cnt == CNT_W'(INTERVAL - 1));
   assign urgent = (pending == PEND_W'(PEND_MAX));

   // Free-running timer plus credit accounting; a wrap and a decrement
   // on the same edge cancel, so overflow only happens without a decrement.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= CNT_W'(OFFSET);
         pending      <= '0;
         overflow_err <= 1'b0;
      end else begin
         cnt <= wrap ? '0 : cnt + 1'b1;
         if (wrap && !dec) begin
            if (urgent) overflow_err <= 1'b1;
            else        pending      <= pending + 1'b1;
         end else if (dec && !wrap) begin
            pending <= pending - 1'b1;
         end
      end
   end

endmodule

// File: rtl/refresh_scheduler.sv
// Multi-bank refresh scheduler: per-bank credit timers, round-robin
// selection from rr_ptr, and a req/ack/done handshake to the command path.
// Urgent banks (credit limit reached) bypass refresh_enable and bank_busy.
module refresh_scheduler
   import refresh_pkg::*;
#(
   parameter int NUM_BANKS    = 4,
   parameter int INTERVAL     = 5000,
   parameter int MAX_POSTPONE = 3,
   parameter int STAGGER      = 1,
   localparam int BANK_W      = bank_w(NUM_BANKS),
   localparam int PEND_W      = pend_w(MAX_POSTPONE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 refresh_enable,
   input  logic [NUM_BANKS-1:0] bank_busy,
   input  logic                 ref_ack,
   input  logic                 ref_done,
   output logic                 ref_req,
   output logic [BANK_W-1:0]    ref_bank,
   output logic                 ref_urgent,
   output logic                 sched_busy,
   output logic                 pending_any,
   output logic [NUM_BANKS-1:0] overflow_err
);

   sched_state_t         state;
   logic [BANK_W-1:0]    rr_ptr;
   logic [BANK_W-1:0]    rr_next;
   logic [PEND_W-1:0]    pending [NUM_BANKS];
   logic [NUM_BANKS-1:0] urgent;
   logic [NUM_BANKS-1:0] has_credit;
   logic [NUM_BANKS-1:0] dec;
   logic                 urg_found;
   logic                 norm_found;
   logic [BANK_W-1:0]    urg_sel;
   logic [BANK_W-1:0]    norm_sel;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      localparam int OFFSET = (STAGGER != 0) ? b * (INTERVAL / NUM_BANKS) : 0;

      assign dec[b]        = (state == REQ) && ref_ack && (ref_bank == BANK_W'(b));
      assign has_credit[b] = (pending[b] != '0);

      refresh_bank_timer #(
         .INTERVAL     (INTERVAL),
         .MAX_POSTPONE (MAX_POSTPONE),
         .OFFSET       (OFFSET)
      ) u_timer (
         .clk          (clk),
         .rst          (rst),
         .dec          (dec[b]),
         .pending      (pending[b]),
         .urgent       (urgent[b]),
         .overflow_err (overflow_err[b])
      );
   end

   assign pending_any = |has_credit;
   assign rr_next     = (ref_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : ref_bank + 1'b1;

   // First urgent / first eligible bank at or after rr_ptr; scanning from the
   // far end and overwriting leaves the closest match to rr_ptr.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      logic [BANK_W-1:0] idx;
      idx        = '0;
      urg_found  = 1'b0;
      norm_found = 1'b0;
      urg_sel    = '0;
      norm_sel   = '0;
      for (int i = NUM_BANKS - 1; i >= 0; i--) begin
         idx = BANK_W'((int'(rr_ptr) + i) % NUM_BANKS);
         if (urgent[idx]) begin
            urg_found = 1'b1;
            urg_sel   = idx;
         end
         if (has_credit[idx] && !bank_busy[idx]) begin
            norm_found = 1'b1;
            norm_sel   = idx;
         end
      end
   end

   // Handshake FSM with registered request outputs and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         ref_req    <= 1'b0;
         ref_bank   <= '0;
         ref_urgent <= 1'b0;
         sched_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (urg_found) begin
                  state      <= REQ;
                  ref_req    <= 1'b1;
                  sched_busy <= 1'b1;
                  ref_bank   <= urg_sel;
                  ref_urgent <= 1'b1;
               end else if (refresh_enable && norm_found) begin
                  state      <= REQ;
                  ref_req    <= 1'b1;
                  sched_busy <= 1'b1;
                  ref_bank   <= norm_sel;
                  ref_urgent <= 1'b0;
               end
            end
            REQ: begin
               if (ref_ack) begin
                  state   <= BUSY;
                  ref_req <= 1'b0;
               end
            end
            BUSY: begin
               if (ref_done) begin
                  state      <= IDLE;
                  sched_busy <= 1'b0;
                  rr_ptr     <= rr_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_refresh_scheduler.sv
// Bench for refresh_scheduler: directed literal checks on a single-bank and a
// staggered instance, and a reference-model comparison on a 4-bank instance.
module tb_refresh_scheduler;

   localparam int NB   = 4;
   localparam int IV   = 16;
   localparam int MP   = 2;
   localparam int PMAX = MP + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // main instance (STAGGER=0)
   logic          rst = 1'b1, en = 1'b0, ack = 1'b0, done = 1'b0;
   logic [NB-1:0] busy = '0;
   logic          req, urg, sbusy, pany;
   logic [1:0]    bank;
   logic [NB-1:0] ovf;

   // staggered instance
   logic          rst_s = 1'b1, ack_s = 1'b0, done_s = 1'b0, en_s = 1'b1;
   logic [NB-1:0] busy_s = '0;
   logic          req_s, urg_s, sbusy_s, pany_s;
   logic [1:0]    bank_s;
   logic [NB-1:0] ovf_s;

   // single-bank instance
   logic          rst_o = 1'b1, ack_o = 1'b0, done_o = 1'b0, en_o = 1'b1;
   logic [0:0]    busy_o = 1'b0;
   logic          req_o, urg_o, sbusy_o, pany_o;
   logic [0:0]    bank_o;
   logic [0:0]    ovf_o;

   refresh_scheduler #(.NUM_BANKS(NB), .INTERVAL(IV), .MAX_POSTPONE(MP), .STAGGER(0)) u_dut (
      .clk(clk), .rst(rst), .refresh_enable(en), .bank_busy(busy), .ref_ack(ack), .ref_done(done),
      .ref_req(req), .ref_bank(bank), .ref_urgent(urg), .sched_busy(sbusy),
      .pending_any(pany), .overflow_err(ovf));

   refresh_scheduler #(.NUM_BANKS(NB), .INTERVAL(IV), .MAX_POSTPONE(MP), .STAGGER(1)) u_stg (
      .clk(clk), .rst(rst_s), .refresh_enable(en_s), .bank_busy(busy_s), .ref_ack(ack_s), .ref_done(done_s),
      .ref_req(req_s), .ref_bank(bank_s), .ref_urgent(urg_s), .sched_busy(sbusy_s),
      .pending_any(pany_s), .overflow_err(ovf_s));

   refresh_scheduler #(.NUM_BANKS(1), .INTERVAL(IV), .MAX_POSTPONE(MP), .STAGGER(0)) u_one (
      .clk(clk), .rst(rst_o), .refresh_enable(en_o), .bank_busy(busy_o), .ref_ack(ack_o), .ref_done(done_o),
      .ref_req(req_o), .ref_bank(bank_o), .ref_urgent(urg_o), .sched_busy(sbusy_o),
      .pending_any(pany_o), .overflow_err(ovf_o));

   // reference model: phase 0 = idle, 1 = requesting, 2 = refresh running
   int            m_pend [NB];
   logic [NB-1:0] m_ovf;
   int            m_phase, m_rr, m_bank;
   logic          m_urg, m_req_q;
   int            lg_n;
   int            lg_edge [8];
   int            lg_bank [8];
   int            lg_urg  [8];

   // command-path responder
   bit in_busy;
   int cnt, rcnt, ack_dly, done_dly;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < NB; b++) m_pend[b] = 0;
      m_ovf   = '0;
      m_phase = 0;
      m_rr    = 0;
      m_bank  = 0;
      m_urg   = 1'b0;
      m_req_q = 1'b0;
      lg_n    = 0;
   endtask

   // Advance the model across rising edge number e (counted from reset release).
   task automatic model_step(input int e);
      bit ufound, nfound, dvalid, credit;
      int usel, nsel;
      ufound = 0; nfound = 0; dvalid = 0; usel = 0; nsel = 0;
      case (m_phase)
         0: begin
            for (int i = 0; i < NB; i++) begin
               int b;
               b = (m_rr + i) % NB;
               if (!ufound && m_pend[b] == PMAX) begin ufound = 1; usel = b; end
               if (!nfound && m_pend[b] > 0 && !busy[b]) begin nfound = 1; nsel = b; end
            end
            if (ufound) begin
               m_phase = 1; m_bank = usel; m_urg = 1'b1;
            end else if (en && nfound) begin
               m_phase = 1; m_bank = nsel; m_urg = 1'b0;
            end
         end
         1: if (ack) begin m_phase = 2; dvalid = 1; end
         default: if (done) begin m_rr = (m_bank + 1) % NB; m_phase = 0; end
      endcase
      for (int b = 0; b < NB; b++) begin
         credit = ((e % IV) == 0);
         if (credit && !(dvalid && m_bank == b)) begin
            if (m_pend[b] == PMAX) m_ovf[b] = 1'b1;
            else m_pend[b]++;
         end else if (!credit && dvalid && m_bank == b) begin
            m_pend[b]--;
         end
      end
   endtask

   task automatic compare_cycle();
      logic exp_req, any;
      exp_req = (m_phase == 1);
      any     = 1'b0;
      for (int b = 0; b < NB; b++) if (m_pend[b] > 0) any = 1'b1;
      check("ref_req", req, exp_req);
      check("sched_busy", sbusy, m_phase != 0);
      check("pending_any", pany, any);
      check("overflow_err", ovf, m_ovf);
      if (exp_req) begin
         check("ref_bank", bank, m_bank);
         check("ref_urgent", urg, m_urg);
      end
      m_req_q = exp_req;
   endtask

   task automatic log_issue(input int k);
      if (m_phase == 1 && !m_req_q && lg_n < 8) begin
         lg_edge[lg_n] = k;
         lg_bank[lg_n] = m_bank;
         lg_urg[lg_n]  = m_urg;
         lg_n++;
      end
   endtask

   // Hand-derived expectations that pin the model.
   task automatic literals(input int seg, input int k);
      if (seg == 0 && k == 40) begin
         check("lit_first_edge", lg_edge[0], 17);
         check("lit_second_edge", lg_edge[1], 22);
         check("lit_third_edge", lg_edge[2], 27);
         check("lit_order0", lg_bank[0], 0);
         check("lit_order1", lg_bank[1], 2);
         check("lit_order2", lg_bank[2], 3);
         check("lit_first_urgent", lg_urg[0], 0);
      end
      if (seg == 1) begin
         if (k == 47) check("lit_pend_e47", m_pend[0], 2);
         if (k == 48) check("lit_pend_e48", m_pend[0], 3);
         if (k == 63) check("lit_no_ovf_e63", m_ovf, 4'b0000);
         if (k == 64) begin
            check("lit_ovf_e64", m_ovf, 4'b1110);
            check("lit_wrap_ack_pend", m_pend[0], 3);
            check("lit_urgent_edge", lg_edge[0], 49);
            check("lit_urgent_bank", lg_bank[0], 0);
            check("lit_urgent_flag", lg_urg[0], 1);
         end
      end
   endtask

   task automatic drive(input int seg, input int k);
      bit resp_on, noise;
      if (seg == 0) begin
         en = 1'b1; busy = 4'b0010;
      end else if (seg == 1) begin
         en = 1'b0; busy = '0;
      end else begin
         if ($urandom_range(0, 15) == 0) en = ~en;
         if ($urandom_range(0, 7) == 0) busy = NB'($urandom);
      end
      resp_on = !(seg == 1 && k >= 49 && k < 63);
      noise   = (seg == 2);
      ack  = 1'b0;
      done = 1'b0;
      if (in_busy) begin
         cnt++;
         if (cnt >= done_dly) begin
            done    = 1'b1;
            in_busy = 0;
            if (noise) begin
               ack_dly  = $urandom_range(0, 3);
               done_dly = $urandom_range(1, 4);
            end
         end
      end else begin
         if (noise && $urandom_range(0, 3) == 0) done = 1'b1;
         if (req) begin
            if (resp_on) begin
               if (rcnt >= ack_dly) begin
                  ack = 1'b1; in_busy = 1; cnt = 0; rcnt = 0;
               end else begin
                  rcnt++;
               end
            end
         end else if (noise && $urandom_range(0, 3) == 0) begin
            ack = 1'b1;
         end
      end
      // ack lands on the same edge as the bank 0 timer wrap
      if (seg == 1 && k == 63) begin
         ack = 1'b1; in_busy = 1; cnt = 0;
      end
   endtask

   task automatic run_seg(input int seg, input int ncyc);
      @(negedge clk);
      rst = 1'b1; en = 1'b0; busy = '0; ack = 1'b0; done = 1'b0;
      #1;
      check("rst_ref_req", req, 1'b0);
      check("rst_sched_busy", sbusy, 1'b0);
      check("rst_pending_any", pany, 1'b0);
      check("rst_overflow_err", ovf, '0);
      check("rst_ref_bank", bank, '0);
      check("rst_ref_urgent", urg, 1'b0);
      model_reset();
      in_busy = 0; cnt = 0; rcnt = 0; ack_dly = 0; done_dly = 3;
      @(negedge clk);
      drive(seg, 0);
      rst = 1'b0;
      model_step(1);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         log_issue(k);
         compare_cycle();
         literals(seg, k);
         drive(seg, k);
         model_step(k + 1);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);

      // single bank: credit at edge 16, request at 17, repeat at 33
      rst_o = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 15) check("one_pany_e15", pany_o, 1'b0);
         if (k == 16) begin
            check("one_pany_e16", pany_o, 1'b1);
            check("one_req_e16", req_o, 1'b0);
         end
         if (k == 17) begin
            check("one_req_e17", req_o, 1'b1);
            check("one_bank_e17", bank_o, 1'b0);
            check("one_urg_e17", urg_o, 1'b0);
         end
         if (k == 18) begin
            check("one_req_e18", req_o, 1'b0);
            check("one_pany_e18", pany_o, 1'b0);
            check("one_busy_e18", sbusy_o, 1'b1);
         end
         if (k == 21) check("one_busy_e21", sbusy_o, 1'b0);
         if (k == 33) begin
            check("one_req_e33", req_o, 1'b1);
            check("one_urg_e33", urg_o, 1'b0);
         end
         ack_o  = (k == 17 || k == 33);
         done_o = (k == 20 || k == 36);
      end
      check("one_ovf_end", ovf_o, 1'b0);

      // staggered: bank 3 credits at edge 4, bank 2 at edge 8; reset during BUSY
      rst_s = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 3) check("stg_pany_e3", pany_s, 1'b0);
         if (k == 4) begin
            check("stg_pany_e4", pany_s, 1'b1);
            check("stg_req_e4", req_s, 1'b0);
         end
         if (k == 5) begin
            check("stg_req_e5", req_s, 1'b1);
            check("stg_bank_e5", bank_s, 2'd3);
            check("stg_urg_e5", urg_s, 1'b0);
         end
         if (k == 8) begin
            check("stg_busy_e8", sbusy_s, 1'b1);
            check("stg_pany_e8", pany_s, 1'b1);
         end
         ack_s = (k == 5);
      end
      #1 rst_s = 1'b1;
      #1;
      check("stg_rst_req", req_s, 1'b0);
      check("stg_rst_busy", sbusy_s, 1'b0);
      check("stg_rst_pany", pany_s, 1'b0);
      check("stg_rst_ovf", ovf_s, '0);
      @(negedge clk);
      rst_s = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 3) check("stg2_pany_e3", pany_s, 1'b0);
         if (k == 4) check("stg2_pany_e4", pany_s, 1'b1);
         if (k == 5) begin
            check("stg2_req_e5", req_s, 1'b1);
            check("stg2_bank_e5", bank_s, 2'd3);
         end
      end

      // four banks against the reference model
      run_seg(0, 40);
      run_seg(1, 110);
      run_seg(2, 3000);
      check("lit_random_activity", lg_n, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
